// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: owns the fetch PC and drives the combinational instruction
// memory. Each fetched word is captured with its PC into a small in-order
// prefetch buffer that feeds decode over a valid/ready handshake. Redirects
// flush the buffer and restart fetch at the new target.
// Optional feature macro: IMEM_FETCH_ZERO_HALT_EN (a fetched all-zero word
// halts fetch until the next redirect).
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t          state_r;
  logic [31:0]     pc_r;
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;
  logic            valid_r;
  logic            halted_r;
  logic [31:0]     pc_mem_r    [DEPTH];
  logic [31:0]     instr_mem_r [DEPTH];

  logic            pop_s;
  logic            fetch_s;
  logic            zero_s;
  logic            push_s;
  logic            halt_s;
  logic [CW-1:0]   count_nxt_s;

  assign imem_addr = pc_r;
  assign out_valid = valid_r;
  assign out_instr = instr_mem_r[head_r];
  assign out_pc    = pc_mem_r[head_r];
  assign halted    = halted_r;

  // Handshake, fetch qualification and next occupancy for this cycle.
  always_comb begin
    pop_s       = 1'b0;
    fetch_s     = 1'b0;
    zero_s      = 1'b0;
    push_s      = 1'b0;
    halt_s      = 1'b0;
    count_nxt_s = count_r;

    pop_s = valid_r & out_ready;
    // A full buffer may still fetch when the head leaves in the same cycle.
    if ((state_r == ST_RUN) && !redirect_valid &&
        ((count_r < CW'(DEPTH)) || pop_s)) begin
      fetch_s = 1'b1;
    end else begin
      fetch_s = 1'b0;
    end

`ifdef IMEM_FETCH_ZERO_HALT_EN
    zero_s = (imem_rdata == 32'h0000_0000);
`else
    zero_s = 1'b0;
`endif

    push_s = fetch_s & ~zero_s;
    halt_s = fetch_s & zero_s;

    if (redirect_valid) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Fetch FSM, PC, buffer pointers/storage and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      pc_r     <= RESET_PC;
      head_r   <= {PW{1'b0}};
      tail_r   <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= 32'h0000_0000;
        instr_mem_r[i] <= 32'h0000_0000;
      end
    end else begin
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {CW{1'b0}});
      if (redirect_valid) begin
        // Flush: stale entries vanish, fetch restarts at the word-aligned target.
        state_r  <= ST_RUN;
        halted_r <= 1'b0;
        pc_r     <= {redirect_pc[31:2], 2'b00};
        head_r   <= {PW{1'b0}};
        tail_r   <= {PW{1'b0}};
      end else begin
        if (push_s) begin
          pc_mem_r[tail_r]    <= pc_r;
          instr_mem_r[tail_r] <= imem_rdata;
          tail_r              <= tail_r + PW'(1);
          pc_r                <= pc_r + 32'd4;
        end
        if (pop_s) begin
          head_r <= head_r + PW'(1);
        end
        case (state_r)
          ST_RUN: begin
            if (halt_s) begin
              state_r  <= ST_HALTED;
              halted_r <= 1'b1;
            end
          end
          ST_HALTED: begin
            state_r  <= ST_HALTED;
            halted_r <= 1'b1;
          end
          default: begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Testbench for imem_fetch_ctrl: directed vectors with literal expectations
// plus a queue-based reference model compared on every falling clock edge.
module tb_imem_fetch_ctrl;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_halt;

  imem_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: all words non-zero except an empty slot at 0x10.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0000_0000;
    return (a ^ 32'hC0DE_0000) | 32'h0000_0003;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue fed from the model's own fetch PC.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
    end else begin
      logic        pop;
      logic        fire;
      logic [31:0] w;
      pop = (m_q.size() != 0) && out_ready;
      if (redirect_valid) begin
        m_q.delete();
        m_pc   = redirect_pc & 32'hFFFF_FFFC;
        m_halt = 1'b0;
      end else begin
        fire = !m_halt && ((m_q.size() < DEPTH) || pop);
        w    = mem_word(m_pc);
        if (pop) void'(m_q.pop_front());
        if (fire) begin
`ifdef IMEM_FETCH_ZERO_HALT_EN
          if (w == 32'h0000_0000) begin
            m_halt = 1'b1;
          end else begin
            m_q.push_back('{pc: m_pc, instr: w});
            m_pc = m_pc + 32'd4;
          end
`else
          m_q.push_back('{pc: m_pc, instr: w});
          m_pc = m_pc + 32'd4;
`endif
        end
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cmp_addr", imem_addr, m_pc);
      chk("cmp_valid", {31'b0, out_valid}, {31'b0, (m_q.size() != 0)});
      chk("cmp_halted", {31'b0, halted}, {31'b0, m_halt});
      if (m_q.size() != 0) begin
        chk("cmp_out_pc", out_pc, m_q[0].pc);
        chk("cmp_out_instr", out_instr, m_q[0].instr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    step();
    step();
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0000_0000);
    chk("rst_out_instr", out_instr, 32'h0000_0000);
    chk("rst_halted", {31'b0, halted}, 32'h0);

    // Streaming with out_ready held high.
    rst_n = 1'b1;
    step();
    chk("s0_valid", {31'b0, out_valid}, 32'h1);
    chk("s0_pc", out_pc, 32'h0000_0000);
    chk("s0_instr", out_instr, 32'hC0DE_0003);
    step();
    chk("s1_pc", out_pc, 32'h0000_0004);
    chk("s1_instr", out_instr, 32'hC0DE_0007);
    step();
    chk("s2_pc", out_pc, 32'h0000_0008);
    chk("s2_instr", out_instr, 32'hC0DE_000B);
    step();
    chk("s3_pc", out_pc, 32'h0000_000C);
    chk("s3_instr", out_instr, 32'hC0DE_000F);
    step();
`ifdef IMEM_FETCH_ZERO_HALT_EN
    chk("zh_valid", {31'b0, out_valid}, 32'h0);
    chk("zh_halted", {31'b0, halted}, 32'h1);
    chk("zh_addr", imem_addr, 32'h0000_0010);
    step();
    chk("zh_addr_hold", imem_addr, 32'h0000_0010);
    chk("zh_halted_hold", {31'b0, halted}, 32'h1);
`else
    chk("z_pc", out_pc, 32'h0000_0010);
    chk("z_instr", out_instr, 32'h0000_0000);
    chk("z_halted", {31'b0, halted}, 32'h0);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0000;
    step();
    redirect_valid = 1'b0;
    chk("rd0_halted", {31'b0, halted}, 32'h0);
    chk("rd0_addr", imem_addr, 32'h0000_0000);
    chk("rd0_valid", {31'b0, out_valid}, 32'h0);
    step();
    chk("rd0_pc", out_pc, 32'h0000_0000);

    // Backpressure from reset.
    rst_n     = 1'b0;
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("bp_first_pc", out_pc, 32'h0000_0000);
    step();
    step();
    chk("bp_stall_addr", imem_addr, 32'h0000_0008);
    chk("bp_head_pc", out_pc, 32'h0000_0000);
    step();
    chk("bp_stall_addr2", imem_addr, 32'h0000_0008);
    out_ready = 1'b1;
    step();
    chk("bp_pc4", out_pc, 32'h0000_0004);
    chk("bp_addr_c", imem_addr, 32'h0000_000C);
    step();
    chk("bp_pc8", out_pc, 32'h0000_0008);

    // Redirect while full with a pop in progress.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0101;
    step();
    redirect_valid = 1'b0;
    chk("rd_addr", imem_addr, 32'h0000_0100);
    chk("rd_flush_valid", {31'b0, out_valid}, 32'h0);
    step();
    chk("rd_pc", out_pc, 32'h0000_0100);
    chk("rd_instr", out_instr, 32'hC0DE_0103);

    // Wrap-around of the fetch PC.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_pc0", out_pc, 32'hFFFF_FFFC);
    chk("wr_instr0", out_instr, 32'h3F21_FFFF);
    step();
    chk("wr_pc1", out_pc, 32'h0000_0000);
    chk("wr_addr1", imem_addr, 32'h0000_0004);

    // Asynchronous reset with a full buffer.
    out_ready = 1'b0;
    step();
    step();
    chk("mr_full_addr", imem_addr, 32'h0000_0008);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'b0, out_valid}, 32'h0);
    chk("mr_addr", imem_addr, RESET_PC);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("mr_restart_pc", out_pc, RESET_PC);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch controller that sequences the combinational instruction memory: owns the fetch PC, drives the memory address each cycle, and captures the returned word with its PC into a small in-order prefetch buffer. The buffer feeds the decode stage over a valid/ready handshake. Sits between the instruction memory and the IF/ID boundary of the pipeline. Also accepts PC redirects from branch resolution and flushes stale prefetched instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset.
- `DEPTH`, default 2: prefetch buffer entries; power of two, 2..8.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr` out 32: address to instruction memory; equals the fetch PC register.
- `imem_rdata` in 32: instruction word, combinational from `imem_addr` in the same cycle.
- `redirect_valid` in 1: branch/jump redirect request.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored and treated as 0.
- `out_valid` out 1: buffer head holds a valid instruction.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_instr` out 32: instruction at the buffer head.
- `out_pc` out 32: PC of `out_instr`.
- `halted` out 1: fetch stopped on a zero word; see Configuration.

## Operation
- State machine, 2 states:
  - RUN: fetch enabled.
  - HALTED: no fetch, no push; the buffer still drains.
- Fetch fires in RUN when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle.
- On fetch:
  - push {`imem_addr`, `imem_rdata`} at the tail;
  - fetch PC <= fetch PC + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Pop when `out_valid && out_ready`; removes the head. Push and pop can occur in the same cycle, and `count` is then unchanged.
- `out_instr`/`out_pc` are driven from the head entry; `out_valid = (count != 0)`. They are don't-care when `out_valid` is 0 but must hold stable while `out_valid && !out_ready`.
- Redirect has priority over push and pop. On `redirect_valid`:
  - buffer cleared, `count` <= 0;
  - fetch PC <= {`redirect_pc`[31:2], 2'b00};
  - state <= RUN;
  - no push that cycle; a same-cycle handshake is still counted as consumed by decode.
- Head/tail are pointers of width log2(DEPTH) that wrap naturally. `count` is log2(DEPTH)+1 bits.

## Timing
- Reset values, asynchronous assert:
  - fetch PC = `RESET_PC`, so `imem_addr = RESET_PC`;
  - `count` = 0, `out_valid` = 0, `out_instr` = 0, `out_pc` = 0;
  - `halted` = 0, state RUN.
- First fetch in the first clock edge after `rst_n` deassertion. `out_valid` = 1 one cycle later.
- Fetch-to-output latency: 1 cycle when the buffer is empty.
- Sustained throughput: 1 instruction/cycle with `out_ready` held 1.
- Redirect at edge N: `imem_addr = target` after N. Target instruction is pushed at N+1 and visible on `out_*` after N+1. No stale entry is visible after N.
- Full buffer with `out_ready` = 0: `imem_addr` holds, no memory-side change.
- Reset asserted mid-stream: all buffered entries discarded immediately. Restart is from `RESET_PC`.

## Configuration
- `IMEM_FETCH_ZERO_HALT_EN` defined:
  - a fetched word equal to 32'h0000_0000 (unpopulated memory) is not pushed;
  - fetch PC is not incremented; state <= HALTED and `halted` = 1 from the next cycle;
  - earlier entries still drain; `redirect_valid` returns to RUN and clears `halted`.
- Not defined:
  - zero words are pushed like any other instruction;
  - state is always RUN and `halted` is tied 0.

## Test plan
- Reset, then stream with `out_ready` = 1, memory holding 4 words at 0x0..0xC: `out_pc` = 0x0, 0x4, 0x8, 0xC on consecutive cycles starting 1 cycle after reset release, with `out_instr` matching memory.
- Backpressure, `out_ready` = 0 from reset: `count` reaches 2 and `imem_addr` stalls at 0x8. Release `out_ready`: output order is 0x0, 0x4, 0x8 with no loss or duplication.
- Redirect to 0x0000_0101 while the buffer is full and a pop is in progress: buffer flushed, `imem_addr` = 0x100, next `out_pc` = 0x100 exactly one cycle later.
- Wrap-around: redirect to 0xFFFF_FFFC gives `out_pc` sequence 0xFFFF_FFFC then 0x0000_0000.
- With `IMEM_FETCH_ZERO_HALT_EN`, zero word at 0x10:
  - 0x0..0xC are delivered, then `halted` = 1 and `imem_addr` holds at 0x10, and `out_valid` drops once the buffer is drained;
  - a redirect to 0x0 clears `halted`.
- Without the macro, the same memory delivers `out_pc` = 0x10 with `out_instr` = 0.
- Reset asserted mid-stream with `count` = 2: `out_valid` = 0 and `imem_addr` = `RESET_PC` immediately, without waiting for a clock.
